// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state, widths and operand helpers for the iterative divider
package div_pkg;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_e;

    localparam int W_LEN    = 32;
    localparam int MAX_XLEN = 128;

    function automatic int cnt_width(input int xlen, input int radix);
        return $clog2(xlen / radix + 1);
    endfunction

    // Operands arrive already sign-extended to MAX_XLEN, so the top bit is the sign.
    function automatic logic [MAX_XLEN-1:0] abs_val(input logic [MAX_XLEN-1:0] v);
        return v[MAX_XLEN-1] ? -v : v;
    endfunction

    function automatic logic [MAX_XLEN-1:0] sext32(input logic [31:0] v);
        return {{(MAX_XLEN-32){v[31]}}, v};
    endfunction

endpackage

// File: rtl/div_iter_unit_if.sv
// rtl/div_iter_unit_if.sv - request/response handshake bundle of the divider
interface div_iter_unit_if #(parameter int XLEN = 64);
    logic            in_valid;
    logic            in_ready;
    logic            in_w;
    logic            in_signed;
    logic [XLEN-1:0] in_dividend;
    logic [XLEN-1:0] in_divisor;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_quotient;
    logic [XLEN-1:0] out_remainder;

    modport master (
        output in_valid, in_w, in_signed, in_dividend, in_divisor, out_ready,
        input  in_ready, out_valid, out_quotient, out_remainder
    );

    modport slave (
        input  in_valid, in_w, in_signed, in_dividend, in_divisor, out_ready,
        output in_ready, out_valid, out_quotient, out_remainder
    );
endinterface

// File: rtl/div_iter_unit_step.sv
// rtl/div_iter_unit_step.sv - one combinational restoring-division bit step
module div_step #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] dvd_in,
    input  logic [WIDTH-1:0] dsr,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] dvd_out
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    assign shifted = {rem_in, dvd_in[WIDTH-1]};
    assign diff    = shifted - {1'b0, dsr};
    // A borrow out of the top bit means the trial subtraction failed: restore.
    assign rem_out = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign dvd_out = {dvd_in[WIDTH-2:0], ~diff[WIDTH]};
endmodule

// File: rtl/div_iter_unit.sv
// rtl/div_iter_unit.sv - multi-cycle RISC-V DIV/REM unit, RADIX_BITS quotient bits per cycle
module div_iter_unit
    import div_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int RADIX_BITS = 1
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           flush,
    div_iter_unit_if.slave bus
);
    localparam int CNT_W = cnt_width(XLEN, RADIX_BITS);
    localparam int PAD   = MAX_XLEN - XLEN;

    div_state_e      state;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0] rem_reg, dvd_reg, dsr_reg, q_reg, r_reg;
    logic            w_reg, sgn_reg, q_neg_reg, r_neg_reg;
    logic            in_ready_reg, out_valid_reg;

    logic [MAX_XLEN-1:0] dvd_wide, dsr_wide, dvd_min;
    logic [XLEN-1:0]     mag_dvd, mag_dsr, q_fix, r_fix;
    logic                is_dz, is_ovf;

    function automatic logic [XLEN-1:0] fit(input logic w, input logic [XLEN-1:0] v);
        return w ? XLEN'(sext32(v[31:0])) : v;
    endfunction

    // Normalise both operands to a sign- or zero-extended MAX_XLEN value of width L.
    always_comb begin
        dvd_wide = {{PAD{bus.in_signed & bus.in_dividend[XLEN-1]}}, bus.in_dividend};
        dsr_wide = {{PAD{bus.in_signed & bus.in_divisor[XLEN-1]}}, bus.in_divisor};
        dvd_min  = {{PAD{1'b1}}, 1'b1, {(XLEN-1){1'b0}}};
        if (bus.in_w) begin
            dvd_wide = bus.in_signed ? sext32(bus.in_dividend[31:0]) : MAX_XLEN'(bus.in_dividend[31:0]);
            dsr_wide = bus.in_signed ? sext32(bus.in_divisor[31:0])  : MAX_XLEN'(bus.in_divisor[31:0]);
            dvd_min  = sext32(32'h8000_0000);
        end
        mag_dvd = XLEN'(bus.in_signed ? abs_val(dvd_wide) : dvd_wide);
        mag_dsr = XLEN'(bus.in_signed ? abs_val(dsr_wide) : dsr_wide);
        is_dz   = (dsr_wide == '0);
        is_ovf  = bus.in_signed && (dvd_wide == dvd_min) && (&dsr_wide);
    end

    logic [XLEN-1:0] rem_chain [RADIX_BITS+1];
    logic [XLEN-1:0] dvd_chain [RADIX_BITS+1];

    assign rem_chain[0] = rem_reg;
    assign dvd_chain[0] = dvd_reg;

    for (genvar i = 0; i < RADIX_BITS; i++) begin : g_step
        div_step #(.WIDTH(XLEN)) u_step (
            .rem_in (rem_chain[i]),
            .dvd_in (dvd_chain[i]),
            .dsr    (dsr_reg),
            .rem_out(rem_chain[i+1]),
            .dvd_out(dvd_chain[i+1])
        );
    end

    assign q_fix = (sgn_reg && q_neg_reg) ? -dvd_reg : dvd_reg;
    assign r_fix = (sgn_reg && r_neg_reg) ? -rem_reg : rem_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            rem_reg       <= '0;
            dvd_reg       <= '0;
            dsr_reg       <= '0;
            q_reg         <= '0;
            r_reg         <= '0;
            w_reg         <= 1'b0;
            sgn_reg       <= 1'b0;
            q_neg_reg     <= 1'b0;
            r_neg_reg     <= 1'b0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else if (flush) begin
            state         <= IDLE;
            cnt           <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (bus.in_valid) begin
                    in_ready_reg <= 1'b0;
                    w_reg        <= bus.in_w;
                    sgn_reg      <= bus.in_signed;
                    q_neg_reg    <= dvd_wide[MAX_XLEN-1] ^ dsr_wide[MAX_XLEN-1];
                    r_neg_reg    <= dvd_wide[MAX_XLEN-1];
                    if (is_dz) begin
                        q_reg         <= '1;
                        r_reg         <= fit(bus.in_w, XLEN'(dvd_wide));
                        out_valid_reg <= 1'b1;
                        state         <= DONE;
                    end else if (is_ovf) begin
                        q_reg         <= fit(bus.in_w, XLEN'(dvd_wide));
                        r_reg         <= '0;
                        out_valid_reg <= 1'b1;
                        state         <= DONE;
                    end else begin
                        // W ops park the 32-bit magnitude at the top so the shift feeds it first.
                        rem_reg <= '0;
                        dvd_reg <= bus.in_w ? (mag_dvd << (XLEN - W_LEN)) : mag_dvd;
                        dsr_reg <= mag_dsr;
                        cnt     <= bus.in_w ? CNT_W'(W_LEN / RADIX_BITS) : CNT_W'(XLEN / RADIX_BITS);
                        state   <= CALC;
                    end
                end
                CALC: begin
                    rem_reg <= rem_chain[RADIX_BITS];
                    dvd_reg <= dvd_chain[RADIX_BITS];
                    cnt     <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) state <= FIX;
                end
                FIX: begin
                    q_reg         <= fit(w_reg, q_fix);
                    r_reg         <= fit(w_reg, r_fix);
                    out_valid_reg <= 1'b1;
                    state         <= DONE;
                end
                DONE: if (bus.out_ready) begin
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready      = in_ready_reg;
    assign bus.out_valid     = out_valid_reg;
    assign bus.out_quotient  = q_reg;
    assign bus.out_remainder = r_reg;
endmodule

// File: tb/tb_div_iter_unit.sv
// tb/tb_div_iter_unit.sv - directed and reference-model checks of div_iter_unit at radix 1 and 2
module tb_div_iter_unit;
    logic clock = 1'b0;
    logic v_reset = 1'b1, v_flush = 1'b0, v_valid = 1'b0, v_w = 1'b0, v_s = 1'b0, v_oready = 1'b0;
    logic [63:0] v_a = '0, v_b = '0;
    bit sel = 1'b0;
    int n_err = 0, n_checks = 0;

    always #5 clock = ~clock;

    div_iter_unit_if #(.XLEN(64)) bus ();
    div_iter_unit_if #(.XLEN(64)) bus2 ();

    assign bus.in_valid  = v_valid & ~sel;
    assign bus2.in_valid = v_valid & sel;
    assign bus.in_w = v_w;          assign bus2.in_w = v_w;
    assign bus.in_signed = v_s;     assign bus2.in_signed = v_s;
    assign bus.in_dividend = v_a;   assign bus2.in_dividend = v_a;
    assign bus.in_divisor = v_b;    assign bus2.in_divisor = v_b;
    assign bus.out_ready = v_oready; assign bus2.out_ready = v_oready;

    div_iter_unit #(.XLEN(64), .RADIX_BITS(1)) dut (
        .clock(clock), .reset(v_reset), .flush(v_flush), .bus(bus));
    div_iter_unit #(.XLEN(64), .RADIX_BITS(2)) dut2 (
        .clock(clock), .reset(v_reset), .flush(v_flush), .bus(bus2));

    logic obs_ready, obs_valid;
    logic [63:0] obs_q, obs_r;
    assign obs_ready = sel ? bus2.in_ready : bus.in_ready;
    assign obs_valid = sel ? bus2.out_valid : bus.out_valid;
    assign obs_q     = sel ? bus2.out_quotient : bus.out_quotient;
    assign obs_r     = sel ? bus2.out_remainder : bus.out_remainder;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_op(input bit s_i, input logic w, input logic s, input logic [63:0] a, input logic [63:0] b);
        int n = 0;
        sel = s_i;
        #0;
        while (!obs_ready && n < 300) begin tick(); n++; end
        v_w = w; v_s = s; v_a = a; v_b = b; v_valid = 1'b1;
        tick();
        v_valid = 1'b0;
        v_a = ~a;
        v_b = a ^ b;
    endtask

    task automatic finish_op(output logic [63:0] q, output logic [63:0] r, output int lat);
        lat = 1;
        while (!obs_valid && lat < 300) begin tick(); lat++; end
        chk("out_valid_seen", {63'b0, obs_valid}, 64'd1);
        q = obs_q;
        r = obs_r;
        v_oready = 1'b1;
        tick();
        v_oready = 1'b0;
    endtask

    task automatic run_op(input bit s_i, input logic w, input logic s, input logic [63:0] a, input logic [63:0] b,
                          output logic [63:0] q, output logic [63:0] r, output int lat);
        start_op(s_i, w, s, a, b);
        finish_op(q, r, lat);
    endtask

    function automatic void ref_div(input logic w, input logic s, input logic [63:0] a, input logic [63:0] b,
                                    output logic [63:0] q, output logic [63:0] r);
        logic [31:0] a32, b32, q32, r32;
        if (w) begin
            a32 = a[31:0]; b32 = b[31:0];
            if (b32 == 0) begin q32 = '1; r32 = a32; end
            else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin q32 = a32; r32 = 0; end
            else if (s) begin q32 = $signed(a32) / $signed(b32); r32 = $signed(a32) % $signed(b32); end
            else begin q32 = a32 / b32; r32 = a32 % b32; end
            q = {{32{q32[31]}}, q32};
            r = {{32{r32[31]}}, r32};
        end else begin
            if (b == 0) begin q = '1; r = a; end
            else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin q = a; r = 0; end
            else if (s) begin q = $signed(a) / $signed(b); r = $signed(a) % $signed(b); end
            else begin q = a / b; r = a % b; end
        end
    endfunction

    initial begin
        logic [63:0] q, r, eq, er, a, b;
        int lat, cnt, exp_lat;
        logic w, s;

        repeat (2) @(posedge clock);
        #1 v_reset = 1'b0;
        chk("reset_in_ready", {63'b0, bus.in_ready}, 64'd1);
        chk("reset_out_valid", {63'b0, bus.out_valid}, 64'd0);
        chk("reset_quotient", bus.out_quotient, 64'd0);
        chk("reset_remainder", bus.out_remainder, 64'd0);

        run_op(0, 0, 0, 64'd100, 64'd7, q, r, lat);
        chk("divu_q", q, 64'd14); chk("divu_r", r, 64'd2); chk("divu_lat", 64'(lat), 64'd66);

        run_op(0, 0, 1, -64'd100, 64'd7, q, r, lat);
        chk("div_negdvd_q", q, 64'hFFFF_FFFF_FFFF_FFF2); chk("div_negdvd_r", r, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op(0, 0, 1, 64'd100, -64'd7, q, r, lat);
        chk("div_negdsr_q", q, 64'hFFFF_FFFF_FFFF_FFF2); chk("div_negdsr_r", r, 64'd2);

        run_op(0, 1, 0, 64'h1_8000_0000, 64'd1, q, r, lat);
        chk("divuw_q", q, 64'hFFFF_FFFF_8000_0000); chk("divuw_r", r, 64'd0); chk("divuw_lat", 64'(lat), 64'd34);
        run_op(0, 1, 1, -64'd7, 64'd2, q, r, lat);
        chk("remw_r", r, 64'hFFFF_FFFF_FFFF_FFFF); chk("remw_q", q, 64'hFFFF_FFFF_FFFF_FFFD);

        run_op(0, 0, 0, 64'd55, 64'd0, q, r, lat);
        chk("dz_q", q, 64'hFFFF_FFFF_FFFF_FFFF); chk("dz_r", r, 64'd55); chk("dz_lat", 64'(lat), 64'd1);
        run_op(0, 0, 1, 64'h8000_0000_0000_0000, '1, q, r, lat);
        chk("ovf_q", q, 64'h8000_0000_0000_0000); chk("ovf_r", r, 64'd0); chk("ovf_lat", 64'(lat), 64'd1);
        run_op(0, 1, 1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, q, r, lat);
        chk("ovfw_q", q, 64'hFFFF_FFFF_8000_0000); chk("ovfw_r", r, 64'd0); chk("ovfw_lat", 64'(lat), 64'd1);
        run_op(0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, q, r, lat);
        chk("divu_max_q", q, 64'h0FFF_FFFF_FFFF_FFFF); chk("divu_max_r", r, 64'hF);

        v_oready = 1'b1;
        repeat (3) tick();
        v_oready = 1'b0;
        chk("oready_idle_in_ready", {63'b0, bus.in_ready}, 64'd1);
        chk("oready_idle_out_valid", {63'b0, bus.out_valid}, 64'd0);

        start_op(0, 0, 0, 64'd200, 64'd9);
        lat = 0;
        while (!bus.out_valid && lat < 300) begin tick(); lat++; end
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", {63'b0, bus.out_valid}, 64'd1);
            chk("bp_in_ready", {63'b0, bus.in_ready}, 64'd0);
            chk("bp_q", bus.out_quotient, 64'd22);
            chk("bp_r", bus.out_remainder, 64'd2);
            tick();
        end
        v_oready = 1'b1; tick(); v_oready = 1'b0;
        chk("bp_release_in_ready", {63'b0, bus.in_ready}, 64'd1);
        chk("bp_release_valid", {63'b0, bus.out_valid}, 64'd0);

        start_op(0, 0, 0, 64'd1000, 64'd3);
        repeat (19) tick();
        v_flush = 1'b1; tick(); v_flush = 1'b0;
        chk("flush_in_ready", {63'b0, bus.in_ready}, 64'd1);
        chk("flush_out_valid", {63'b0, bus.out_valid}, 64'd0);
        cnt = 0;
        repeat (80) begin tick(); if (bus.out_valid) cnt++; end
        chk("flush_no_valid", 64'(cnt), 64'd0);

        v_a = 64'd9; v_b = 64'd0; v_w = 0; v_s = 0; v_valid = 1'b1; v_flush = 1'b1;
        tick();
        v_valid = 1'b0; v_flush = 1'b0;
        tick();
        chk("flush_idle_in_ready", {63'b0, bus.in_ready}, 64'd1);
        chk("flush_idle_out_valid", {63'b0, bus.out_valid}, 64'd0);

        run_op(0, 0, 0, 64'h10, 64'h3, q, r, lat);
        chk("fresh_q", q, 64'd5); chk("fresh_r", r, 64'd1);

        start_op(0, 0, 0, 64'd12345, 64'd7);
        repeat (10) tick();
        v_reset = 1'b1; tick(); v_reset = 1'b0;
        chk("midreset_in_ready", {63'b0, bus.in_ready}, 64'd1);
        chk("midreset_out_valid", {63'b0, bus.out_valid}, 64'd0);
        chk("midreset_q", bus.out_quotient, 64'd0);
        chk("midreset_r", bus.out_remainder, 64'd0);

        run_op(1, 0, 0, 64'd1000, 64'd9, q, r, lat);
        chk("r2_q", q, 64'd111); chk("r2_r", r, 64'd1); chk("r2_lat", 64'(lat), 64'd34);
        run_op(1, 1, 1, -64'd7, 64'd2, q, r, lat);
        chk("r2_remw_r", r, 64'hFFFF_FFFF_FFFF_FFFF); chk("r2_w_lat", 64'(lat), 64'd18);

        for (int i = 0; i < 160; i++) begin
            w = 1'($urandom_range(0, 1));
            s = 1'($urandom_range(0, 1));
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            case ($urandom_range(0, 9))
                0: b = 64'd0;
                1: begin b = '1; a = w ? 64'h8000_0000 : 64'h8000_0000_0000_0000; end
                2: b = 64'($urandom_range(1, 15));
                3: b = {32'd0, $urandom};
                4: a = 64'($urandom_range(0, 1000));
                default: ;
            endcase
            ref_div(w, s, a, b, eq, er);
            if ((w && b[31:0] == 0) || (!w && b == 0) ||
                (s && w && a[31:0] == 32'h8000_0000 && b[31:0] == '1) ||
                (s && !w && a == 64'h8000_0000_0000_0000 && b == '1))
                exp_lat = 1;
            else
                exp_lat = (w ? 32 : 64) / ((i % 2) + 1) + 2;
            run_op(1'(i % 2), w, s, a, b, q, r, lat);
            chk($sformatf("rand%0d_q", i), q, eq);
            chk($sformatf("rand%0d_r", i), r, er);
            chk($sformatf("rand%0d_lat", i), 64'(lat), 64'(exp_lat));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
